// File: rtl/jzjpcc_decode_pkg.sv
// jzjpcc_decode_pkg: shared types for the RV32I decode stage.
// Holds ALU op enum, opcode constants, NOP word and the execute bundle.
package jzjpcc_decode_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_JALR   = 7'b1100111;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_FENCE  = 7'b0001111;
    localparam opcode_t OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        alu_op_t     aluOp;
        logic [31:0] operandA;
        logic [31:0] operandB;
        logic [31:0] storeData;
        logic [2:0]  funct3;
        logic [4:0]  rdAddress;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } decoded_bundle_t;

    // ALU_ADD encodes as 0, so an all-zero bundle is the bubble
    localparam decoded_bundle_t BUBBLE = '0;

    function automatic alu_op_t alu_decode(logic [2:0] f3, logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/jzjpcc_decode_immediate_gen.sv
// jzjpcc_immediate_gen: combinational RV32I immediate extraction.
// Ports: i_instr in; o_immI/S/B/U/J sign-extended 32-bit out.
module jzjpcc_immediate_gen (
    input  logic [31:0] i_instr,
    output logic [31:0] o_immI,
    output logic [31:0] o_immS,
    output logic [31:0] o_immB,
    output logic [31:0] o_immU,
    output logic [31:0] o_immJ
);
    logic w_unused;

    assign o_immI = {{20{i_instr[31]}}, i_instr[31:20]};
    assign o_immS = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign o_immB = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                     i_instr[30:25], i_instr[11:8], 1'b0};
    assign o_immU = {i_instr[31:12], 12'b0};
    assign o_immJ = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                     i_instr[20], i_instr[30:21], 1'b0};

    assign w_unused = ^i_instr[6:0];
endmodule

// File: rtl/jzjpcc_decode.sv
// jzjpcc_decode: RV32I decode stage; regfile read, memory-stage forwarding,
// JAL/JALR/branch resolution in decode, and the decode-to-execute register.
// Ports: fetch instr/PC in; regfile addr out/data in; memory-stage forward in;
// pcCTWriteEnable/controlTransferNewPC/stall_fetch/flush_decode out;
// *_execute bundle out. Optional JZJPCC_DECODE_ILLEGAL_TRAP_EN adds a
// sticky illegalInstruction output that halts the core.
module jzjpcc_decode
    import jzjpcc_decode_pkg::*;
#(
    parameter int PC_MAX_B = 31
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:2]         instruction_decode,
    input  logic [PC_MAX_B:2]   currentPC_decode,
    output logic [4:0]          rs1Address_decode,
    output logic [4:0]          rs2Address_decode,
    input  logic [31:0]         rs1Data_decode,
    input  logic [31:0]         rs2Data_decode,
    input  logic [4:0]          rdAddress_memory,
    input  logic                regWrite_memory,
    input  logic [31:0]         rdData_memory,
    output logic                pcCTWriteEnable,
    output logic [PC_MAX_B:2]   controlTransferNewPC,
    output logic                stall_fetch,
    output logic                flush_decode,
    output alu_op_t             aluOp_execute,
    output logic [31:0]         operandA_execute,
    output logic [31:0]         operandB_execute,
    output logic [31:0]         storeData_execute,
    output logic [2:0]          funct3_execute,
    output logic [4:0]          rdAddress_execute,
    output logic                regWrite_execute,
    output logic                memRead_execute,
    output logic                memWrite_execute
`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                illegalInstruction
`endif
);
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
    logic        w_isLui, w_isAuipc, w_isJal, w_isJalr, w_isBranch;
    logic        w_isLoad, w_isStore, w_isOpImm, w_isOp, w_isUndef;
    logic        w_use1, w_use2, w_exHaz1, w_exHaz2;
    logic        w_stall, w_halt, w_hold, w_taken, w_ct;
    logic [31:0] w_rs1Val, w_rs2Val, w_pc32, w_target32;
    logic        w_unused;
    decoded_bundle_t w_next, r_ex;

    assign w_instr  = {instruction_decode, 2'b11};
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_f3     = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_alt    = w_instr[30];

    assign rs1Address_decode = w_rs1;
    assign rs2Address_decode = w_rs2;

    jzjpcc_immediate_gen u_imm (
        .i_instr (w_instr),
        .o_immI  (w_immI),
        .o_immS  (w_immS),
        .o_immB  (w_immB),
        .o_immU  (w_immU),
        .o_immJ  (w_immJ)
    );

    assign w_isLui    = w_opcode == OPC_LUI;
    assign w_isAuipc  = w_opcode == OPC_AUIPC;
    assign w_isJal    = w_opcode == OPC_JAL;
    assign w_isJalr   = w_opcode == OPC_JALR;
    assign w_isBranch = w_opcode == OPC_BRANCH;
    assign w_isLoad   = w_opcode == OPC_LOAD;
    assign w_isStore  = w_opcode == OPC_STORE;
    assign w_isOpImm  = w_opcode == OPC_OP_IMM;
    assign w_isOp     = w_opcode == OPC_OP;
    assign w_isUndef  = !(w_isLui | w_isAuipc | w_isJal | w_isJalr |
                          w_isBranch | w_isLoad | w_isStore |
                          w_isOpImm | w_isOp |
                          (w_opcode == OPC_FENCE) |
                          (w_opcode == OPC_SYSTEM));

    assign w_use1 = w_isJalr | w_isBranch | w_isLoad |
                    w_isStore | w_isOpImm | w_isOp;
    assign w_use2 = w_isBranch | w_isStore | w_isOp;

    assign w_exHaz1 = w_use1 && (w_rs1 != 5'd0) && r_ex.regWrite &&
                      (r_ex.rdAddress == w_rs1);
    assign w_exHaz2 = w_use2 && (w_rs2 != 5'd0) && r_ex.regWrite &&
                      (r_ex.rdAddress == w_rs2);

    // A load result is not ready until memory; control transfers resolve
    // here and cannot wait for execute, so both need the value one stage on
    assign w_stall = (w_exHaz1 | w_exHaz2) &&
                     (r_ex.memRead | w_isBranch | w_isJalr);

    assign w_rs1Val = (w_rs1 == 5'd0) ? 32'd0 :
                      (regWrite_memory && rdAddress_memory == w_rs1) ?
                      rdData_memory : rs1Data_decode;
    assign w_rs2Val = (w_rs2 == 5'd0) ? 32'd0 :
                      (regWrite_memory && rdAddress_memory == w_rs2) ?
                      rdData_memory : rs2Data_decode;

    always_comb begin
        w_pc32 = '0;
        w_pc32[PC_MAX_B:2] = currentPC_decode;
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_taken = w_rs1Val == w_rs2Val;
            3'b001:  w_taken = w_rs1Val != w_rs2Val;
            3'b100:  w_taken = $signed(w_rs1Val) <  $signed(w_rs2Val);
            3'b101:  w_taken = $signed(w_rs1Val) >= $signed(w_rs2Val);
            3'b110:  w_taken = w_rs1Val <  w_rs2Val;
            3'b111:  w_taken = w_rs1Val >= w_rs2Val;
            default: w_taken = 1'b0;
        endcase
    end

`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_illegal <= 1'b0;
        else        r_illegal <= r_illegal | (w_isUndef & ~w_stall);
    end

    assign w_halt = r_illegal;
    assign illegalInstruction = r_illegal;
`else
    assign w_halt = 1'b0;
`endif

    assign w_hold = w_stall | w_halt;

    always_comb begin
        w_next     = BUBBLE;
        w_ct       = 1'b0;
        w_target32 = '0;
        if (!w_hold) begin
            unique case (1'b1)
                w_isLui: begin
                    w_next.operandB  = w_immU;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                end
                w_isAuipc: begin
                    w_next.operandA  = w_pc32;
                    w_next.operandB  = w_immU;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                end
                w_isJal: begin
                    w_next.operandA  = w_pc32;
                    w_next.operandB  = 32'd4;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                    w_ct             = 1'b1;
                    w_target32       = w_pc32 + w_immJ;
                end
                w_isJalr: begin
                    w_next.operandA  = w_pc32;
                    w_next.operandB  = 32'd4;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                    w_ct             = 1'b1;
                    w_target32       = (w_rs1Val + w_immI) & ~32'd1;
                end
                w_isBranch: begin
                    w_ct       = w_taken;
                    w_target32 = w_pc32 + w_immB;
                end
                w_isLoad: begin
                    w_next.operandA  = w_rs1Val;
                    w_next.operandB  = w_immI;
                    w_next.funct3    = w_f3;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                    w_next.memRead   = 1'b1;
                end
                w_isStore: begin
                    w_next.operandA  = w_rs1Val;
                    w_next.operandB  = w_immS;
                    w_next.storeData = w_rs2Val;
                    w_next.funct3    = w_f3;
                    w_next.memWrite  = 1'b1;
                end
                w_isOpImm: begin
                    // bit 30 only distinguishes SRAI; ADDI has no SUB form
                    w_next.aluOp     = alu_decode(w_f3,
                                           w_alt & (w_f3 == 3'b101));
                    w_next.operandA  = w_rs1Val;
                    w_next.operandB  = w_immI;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                end
                w_isOp: begin
                    w_next.aluOp     = alu_decode(w_f3, w_alt);
                    w_next.operandA  = w_rs1Val;
                    w_next.operandB  = w_rs2Val;
                    w_next.rdAddress = w_rd;
                    w_next.regWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pcCTWriteEnable      = w_ct;
    assign flush_decode         = w_ct;
    assign controlTransferNewPC = w_target32[PC_MAX_B:2];
    assign stall_fetch          = w_hold;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_ex <= BUBBLE;
        else        r_ex <= w_next;
    end

    assign aluOp_execute     = r_ex.aluOp;
    assign operandA_execute  = r_ex.operandA;
    assign operandB_execute  = r_ex.operandB;
    assign storeData_execute = r_ex.storeData;
    assign funct3_execute    = r_ex.funct3;
    assign rdAddress_execute = r_ex.rdAddress;
    assign regWrite_execute  = r_ex.regWrite;
    assign memRead_execute   = r_ex.memRead;
    assign memWrite_execute  = r_ex.memWrite;

    assign w_unused = ^{w_target32, w_isUndef};
endmodule

// File: tb/tb_jzjpcc_decode.sv
// tb_jzjpcc_decode: directed and randomized checks of the decode stage
// against an instruction-level reference model.
module tb_jzjpcc_decode;
    import jzjpcc_decode_pkg::*;

    localparam int PC_MAX_B = 31;
    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4;
    localparam int K_LD = 5, K_ST = 6, K_OPI = 7, K_OP = 8, K_MISC = 9;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [31:2]       instruction_decode;
    logic [PC_MAX_B:2] currentPC_decode;
    logic [4:0]        rs1Address_decode, rs2Address_decode;
    logic [31:0]       rs1Data_decode, rs2Data_decode;
    logic [4:0]        rdAddress_memory;
    logic              regWrite_memory;
    logic [31:0]       rdData_memory;
    logic              pcCTWriteEnable;
    logic [PC_MAX_B:2] controlTransferNewPC;
    logic              stall_fetch, flush_decode;
    alu_op_t           aluOp_execute;
    logic [31:0]       operandA_execute, operandB_execute, storeData_execute;
    logic [2:0]        funct3_execute;
    logic [4:0]        rdAddress_execute;
    logic              regWrite_execute, memRead_execute, memWrite_execute;
`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
    logic              illegalInstruction;
`endif

    logic [31:0] rf [32];

    jzjpcc_decode #(.PC_MAX_B(PC_MAX_B)) dut (
        .clock                (clock),
        .reset                (reset),
        .instruction_decode   (instruction_decode),
        .currentPC_decode     (currentPC_decode),
        .rs1Address_decode    (rs1Address_decode),
        .rs2Address_decode    (rs2Address_decode),
        .rs1Data_decode       (rs1Data_decode),
        .rs2Data_decode       (rs2Data_decode),
        .rdAddress_memory     (rdAddress_memory),
        .regWrite_memory      (regWrite_memory),
        .rdData_memory        (rdData_memory),
        .pcCTWriteEnable      (pcCTWriteEnable),
        .controlTransferNewPC (controlTransferNewPC),
        .stall_fetch          (stall_fetch),
        .flush_decode         (flush_decode),
        .aluOp_execute        (aluOp_execute),
        .operandA_execute     (operandA_execute),
        .operandB_execute     (operandB_execute),
        .storeData_execute    (storeData_execute),
        .funct3_execute       (funct3_execute),
        .rdAddress_execute    (rdAddress_execute),
        .regWrite_execute     (regWrite_execute),
        .memRead_execute      (memRead_execute),
        .memWrite_execute     (memWrite_execute)
`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
        ,
        .illegalInstruction   (illegalInstruction)
`endif
    );

    always #5 clock = ~clock;

    assign rs1Data_decode = rf[rs1Address_decode];
    assign rs2Data_decode = rf[rs2Address_decode];

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encI(logic [31:0] im, logic [4:0] s1,
                                         logic [2:0] f, logic [4:0] d,
                                         logic [6:0] op);
        return {im[11:0], s1, f, d, op};
    endfunction

    function automatic logic [31:0] encS(logic [31:0] im, logic [4:0] s2,
                                         logic [4:0] s1, logic [2:0] f);
        return {im[11:5], s2, s1, f, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(logic [31:0] im, logic [4:0] s2,
                                         logic [4:0] s1, logic [2:0] f);
        return {im[12], im[10:5], s2, s1, f, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(logic [31:0] im, logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    function automatic logic [31:0] encR(logic [6:0] f7, logic [4:0] s2,
                                         logic [4:0] s1, logic [2:0] f,
                                         logic [4:0] d);
        return {f7, s2, s1, f, d, 7'b0110011};
    endfunction

    task automatic put(logic [31:0] ins, logic [31:0] pc);
        instruction_decode = ins[31:2];
        currentPC_decode   = pc[PC_MAX_B:2];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] ins, pc, imm, v1, v2, e_a, e_b, e_sd, e_tgt;
    logic [19:0] uimm;
    logic [4:0]  rd, rs1, rs2, e_rd, prev_rd, held_rd;
    logic [2:0]  f3, e_f3;
    logic        alt;
    int          kind;
    bit          e_rw, e_mr, e_mw, e_ct, e_stall, a_ok, b_ok, sd_ok;
    bit          use1, use2, ex1, ex2, ctrl, prev_rw, prev_mr, hold;
    bit          taken;
    alu_op_t     e_op;
    alu_op_t     optab [8];
    logic [2:0]  brf3 [6];
    logic [2:0]  ldf3 [5];
    logic [31:0] miscw [3];

    initial begin
        optab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                  ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        brf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        ldf3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        miscw = '{32'h0000_000F, 32'h0000_0073, 32'h0000_007F};
        for (int i = 0; i < 32; i++) rf[i] = 32'h1111_0000 + 32'(i);
        rf[2] = 32'h0000_1000;
        rf[4] = 32'd7;
        rf[7] = 32'h77;
        rf[9] = 32'h203;
        regWrite_memory  = 1'b0;
        rdAddress_memory = 5'd0;
        rdData_memory    = 32'd0;

        // reset with ADDI x1,x0,5 present
        reset = 1'b0;
        put(32'h0050_0093, 32'h0);
        tick();
        tick();
        chk("rst_rw", 32'(regWrite_execute), 32'd0);
        chk("rst_mr", 32'(memRead_execute), 32'd0);
        chk("rst_mw", 32'(memWrite_execute), 32'd0);
        chk("rst_rd", 32'(rdAddress_execute), 32'd0);
        chk("rst_a", operandA_execute, 32'd0);
        chk("rst_b", operandB_execute, 32'd0);
        chk("rst_sd", storeData_execute, 32'd0);
        chk("rst_alu", 32'(aluOp_execute), 32'(ALU_ADD));
        reset = 1'b1;
        tick();
        chk("addi_rd", 32'(rdAddress_execute), 32'd1);
        chk("addi_a", operandA_execute, 32'd0);
        chk("addi_b", operandB_execute, 32'd5);
        chk("addi_rw", 32'(regWrite_execute), 32'd1);

        // asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1;
        chk("async_rw", 32'(regWrite_execute), 32'd0);
        chk("async_b", operandB_execute, 32'd0);
        reset = 1'b1;

        // JAL x1,+0x20 at 0x100
        put(encJ(32'h20, 5'd1), 32'h100);
        #2;
        chk("jal_ct", 32'(pcCTWriteEnable), 32'd1);
        chk("jal_flush", 32'(flush_decode), 32'd1);
        chk("jal_tgt", 32'(controlTransferNewPC), 32'h48);
        chk("jal_stall", 32'(stall_fetch), 32'd0);
        tick();
        chk("jal_a", operandA_execute, 32'h100);
        chk("jal_b", operandB_execute, 32'd4);
        chk("jal_rd", 32'(rdAddress_execute), 32'd1);
        chk("jal_rw", 32'(regWrite_execute), 32'd1);

        // LW x5,0(x2) then ADD x6,x5,x7
        put(encI(32'd0, 5'd2, 3'd2, 5'd5, 7'b0000011), 32'h104);
        #2 chk("lw_stall", 32'(stall_fetch), 32'd0);
        tick();
        chk("lw_mr", 32'(memRead_execute), 32'd1);
        chk("lw_a", operandA_execute, 32'h1000);
        put(encR(7'd0, 5'd7, 5'd5, 3'd0, 5'd6), 32'h108);
        #2;
        chk("lu_stall", 32'(stall_fetch), 32'd1);
        chk("lu_ct", 32'(pcCTWriteEnable), 32'd0);
        chk("lu_flush", 32'(flush_decode), 32'd0);
        tick();
        chk("lu_bubble", 32'(regWrite_execute), 32'd0);
        regWrite_memory  = 1'b1;
        rdAddress_memory = 5'd5;
        rdData_memory    = 32'hDEAD_BEEF;
        #2 chk("lu_stall2", 32'(stall_fetch), 32'd0);
        tick();
        chk("lu_a", operandA_execute, 32'hDEAD_BEEF);
        chk("lu_b", operandB_execute, 32'h77);
        chk("lu_rd", 32'(rdAddress_execute), 32'd6);

        // ADDI x3,x0,7 then BEQ x3,x4,-8 at 0x40
        regWrite_memory = 1'b0;
        put(encI(32'd7, 5'd0, 3'd0, 5'd3, 7'b0010011), 32'h3C);
        tick();
        chk("addi3_rd", 32'(rdAddress_execute), 32'd3);
        put(encB(32'hFFFF_FFF8, 5'd4, 5'd3, 3'd0), 32'h40);
        #2;
        chk("beq_stall", 32'(stall_fetch), 32'd1);
        chk("beq_ct0", 32'(pcCTWriteEnable), 32'd0);
        tick();
        chk("beq_bubble", 32'(regWrite_execute), 32'd0);
        regWrite_memory  = 1'b1;
        rdAddress_memory = 5'd3;
        rdData_memory    = 32'd7;
        #2;
        chk("beq_stall2", 32'(stall_fetch), 32'd0);
        chk("beq_ct", 32'(pcCTWriteEnable), 32'd1);
        chk("beq_flush", 32'(flush_decode), 32'd1);
        chk("beq_tgt", 32'(controlTransferNewPC), 32'hE);
        tick();
        chk("beq_rw", 32'(regWrite_execute), 32'd0);

        // JALR x0,0(x9), x9=0x203
        regWrite_memory = 1'b0;
        put(encI(32'd0, 5'd9, 3'd0, 5'd0, 7'b1100111), 32'h44);
        #2;
        chk("jalr_stall", 32'(stall_fetch), 32'd0);
        chk("jalr_ct", 32'(pcCTWriteEnable), 32'd1);
        chk("jalr_tgt", 32'(controlTransferNewPC), 32'h80);
        tick();
        chk("jalr_a", operandA_execute, 32'h44);
        chk("jalr_b", operandB_execute, 32'd4);

        // randomized sequence against the instruction-level model
        reset = 1'b0;
        #1 reset = 1'b1;
        prev_rw = 0;
        prev_mr = 0;
        prev_rd = 5'd0;
        hold    = 0;
        held_rd = 5'd0;
        for (int it = 0; it < 400; it++) begin
            if (!hold) begin
`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
                kind = $urandom_range(0, 8);
`else
                kind = $urandom_range(0, 9);
`endif
                rd   = 5'($urandom_range(0, 7));
                rs1  = 5'($urandom_range(0, 7));
                rs2  = 5'($urandom_range(0, 7));
                f3   = 3'($urandom_range(0, 7));
                alt  = 1'($urandom_range(0, 1));
                imm  = 32'(int'($urandom_range(0, 4095)) - 2048);
                uimm = 20'($urandom);
                pc   = $urandom & 32'hFFFF_FFFC;
                case (kind)
                    K_LUI:   ins = {uimm, rd, 7'b0110111};
                    K_AUIPC: ins = {uimm, rd, 7'b0010111};
                    K_JAL: begin
                        imm = 32'((int'($urandom_range(0, (1 << 20) - 1))
                                   - (1 << 19)) * 2);
                        ins = encJ(imm, rd);
                    end
                    K_JALR: ins = encI(imm, rs1, 3'd0, rd, 7'b1100111);
                    K_BR: begin
                        f3  = brf3[$urandom_range(0, 5)];
                        imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                        ins = encB(imm, rs2, rs1, f3);
                    end
                    K_LD: begin
                        f3  = ldf3[$urandom_range(0, 4)];
                        ins = encI(imm, rs1, f3, rd, 7'b0000011);
                    end
                    K_ST: begin
                        f3  = 3'($urandom_range(0, 2));
                        ins = encS(imm, rs2, rs1, f3);
                    end
                    K_OPI: begin
                        if (f3 == 3'd1) imm = 32'($urandom_range(0, 31));
                        if (f3 == 3'd5)
                            imm = 32'($urandom_range(0, 31)) |
                                  (alt ? 32'h400 : 32'h0);
                        ins = encI(imm, rs1, f3, rd, 7'b0010011);
                    end
                    K_OP: begin
                        if (!(f3 == 3'd0 || f3 == 3'd5)) alt = 1'b0;
                        ins = encR({1'b0, alt, 5'd0}, rs2, rs1, f3, rd);
                    end
                    default: begin
`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
                        ins = miscw[$urandom_range(0, 1)];
`else
                        ins = miscw[$urandom_range(0, 2)];
`endif
                    end
                endcase
            end
            if (hold) begin
                regWrite_memory  = 1'b1;
                rdAddress_memory = held_rd;
            end else begin
                regWrite_memory  = 1'($urandom_range(0, 1));
                rdAddress_memory = 5'($urandom_range(0, 7));
            end
            rdData_memory = $urandom;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            put(ins, pc);

            v1 = (rs1 == 0) ? 32'd0 :
                 (regWrite_memory && rdAddress_memory == rs1) ?
                 rdData_memory : rf[rs1];
            v2 = (rs2 == 0) ? 32'd0 :
                 (regWrite_memory && rdAddress_memory == rs2) ?
                 rdData_memory : rf[rs2];
            use1 = kind inside {K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP};
            use2 = kind inside {K_BR, K_ST, K_OP};
            ctrl = kind inside {K_JALR, K_BR};
            ex1  = use1 && prev_rw && prev_rd == rs1 && rs1 != 0;
            ex2  = use2 && prev_rw && prev_rd == rs2 && rs2 != 0;
            e_stall = (ex1 || ex2) && (prev_mr || ctrl);
            a_ok  = !ex1;
            b_ok  = !ex2;
            sd_ok = !ex2;
            e_rw = 0; e_mr = 0; e_mw = 0; e_ct = 0;
            e_rd = 5'd0; e_a = 32'd0; e_b = 32'd0; e_sd = 32'd0;
            e_f3 = 3'd0; e_op = ALU_ADD; e_tgt = 32'd0;
            if (!e_stall) begin
                case (kind)
                    K_LUI: begin
                        e_rw = 1; e_rd = rd; e_b = {uimm, 12'd0};
                    end
                    K_AUIPC: begin
                        e_rw = 1; e_rd = rd; e_a = pc; e_b = {uimm, 12'd0};
                    end
                    K_JAL: begin
                        e_rw = 1; e_rd = rd; e_a = pc; e_b = 32'd4;
                        e_ct = 1; e_tgt = pc + imm;
                    end
                    K_JALR: begin
                        e_rw = 1; e_rd = rd; e_a = pc; e_b = 32'd4;
                        e_ct = 1; e_tgt = (v1 + imm) & 32'hFFFF_FFFE;
                    end
                    K_BR: begin
                        case (f3)
                            3'd0:    taken = v1 == v2;
                            3'd1:    taken = v1 != v2;
                            3'd4:    taken = $signed(v1) <  $signed(v2);
                            3'd5:    taken = $signed(v1) >= $signed(v2);
                            3'd6:    taken = v1 < v2;
                            default: taken = v1 >= v2;
                        endcase
                        e_ct = taken; e_tgt = pc + imm;
                    end
                    K_LD: begin
                        e_rw = 1; e_mr = 1; e_rd = rd;
                        e_a = v1; e_b = imm; e_f3 = f3;
                    end
                    K_ST: begin
                        e_mw = 1; e_a = v1; e_b = imm; e_sd = v2; e_f3 = f3;
                    end
                    K_OPI: begin
                        e_rw = 1; e_rd = rd; e_a = v1; e_b = imm;
                        e_op = (f3 == 3'd5 && alt) ? ALU_SRA : optab[f3];
                    end
                    K_OP: begin
                        e_rw = 1; e_rd = rd; e_a = v1; e_b = v2;
                        e_op = optab[f3];
                        if (f3 == 3'd0 && alt) e_op = ALU_SUB;
                        if (f3 == 3'd5 && alt) e_op = ALU_SRA;
                    end
                    default: ;
                endcase
            end

            #2;
            chk("r_rs1addr", 32'(rs1Address_decode), 32'(ins[19:15]));
            chk("r_rs2addr", 32'(rs2Address_decode), 32'(ins[24:20]));
            chk("r_stall", 32'(stall_fetch), 32'(e_stall));
            chk("r_ct", 32'(pcCTWriteEnable), 32'(e_ct));
            chk("r_flush", 32'(flush_decode), 32'(e_ct));
            if (e_ct) chk("r_tgt", 32'(controlTransferNewPC), 32'(e_tgt[31:2]));
            tick();
            chk("r_rw", 32'(regWrite_execute), 32'(e_rw));
            chk("r_mr", 32'(memRead_execute), 32'(e_mr));
            chk("r_mw", 32'(memWrite_execute), 32'(e_mw));
            if (e_rw) chk("r_rd", 32'(rdAddress_execute), 32'(e_rd));
            if (e_rw || e_mw) begin
                chk("r_alu", 32'(aluOp_execute), 32'(e_op));
                if (a_ok) chk("r_a", operandA_execute, e_a);
                if (b_ok) chk("r_b", operandB_execute, e_b);
            end
            if (e_mr || e_mw) chk("r_f3", 32'(funct3_execute), 32'(e_f3));
            if (e_mw && sd_ok) chk("r_sd", storeData_execute, e_sd);

            if (e_stall) held_rd = prev_rd;
            hold    = e_stall;
            prev_rw = e_rw;
            prev_mr = e_mr;
            prev_rd = e_rd;
        end

`ifdef JZJPCC_DECODE_ILLEGAL_TRAP_EN
        reset = 1'b0;
        #1 reset = 1'b1;
        regWrite_memory = 1'b0;
        put(32'hFFFF_FFFF, 32'h0);
        #2 chk("trap_stall0", 32'(stall_fetch), 32'd0);
        tick();
        chk("trap_ill", 32'(illegalInstruction), 32'd1);
        chk("trap_stall", 32'(stall_fetch), 32'd1);
        put(32'h0050_0093, 32'h4);
        tick();
        tick();
        chk("trap_hold", 32'(stall_fetch), 32'd1);
        chk("trap_bubble", 32'(regWrite_execute), 32'd0);
        chk("trap_ill2", 32'(illegalInstruction), 32'd1);
        reset = 1'b0;
        #1;
        chk("trap_clr", 32'(illegalInstruction), 32'd0);
        reset = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
